// File: rtl/bp_be_prefetch_scheduler.sv
// Round-robin scheduler sharing one prefetch generator between striding-load requesters.
// Define BP_BE_PREFETCH_SCHED_DEDUP_EN to drop requests repeating the last forwarded pc/block.
module bp_be_prefetch_scheduler #(
  parameter int vaddr_width_p = 39
 ,parameter int num_req_p = 2
 ,parameter int loop_range_p = 8
 ,parameter int stride_width_p = 8
 ,parameter int gap_width_p = 4
`ifdef BP_BE_PREFETCH_SCHED_DEDUP_EN
 ,parameter int dcache_block_width_p = 512
`endif
 ,localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic clk_i
 ,input  logic reset_i
 ,input  logic enable_i
 ,input  logic flush_i
 ,input  logic [gap_width_p-1:0] gap_i
 ,input  logic [num_req_p-1:0] req_v_i
 ,output logic [num_req_p-1:0] req_ready_and_o
 ,input  logic [num_req_p*vaddr_width_p-1:0] req_pc_i
 ,input  logic [num_req_p*loop_range_p-1:0] req_loop_counter_i
 ,input  logic [num_req_p*vaddr_width_p-1:0] req_eff_addr_i
 ,input  logic [num_req_p*stride_width_p-1:0] req_stride_i
 ,output logic gen_v_o
 ,input  logic gen_ready_and_i
 ,output logic [vaddr_width_p-1:0] gen_pc_o
 ,output logic [loop_range_p-1:0] gen_loop_counter_o
 ,output logic [vaddr_width_p-1:0] gen_eff_addr_o
 ,output logic [stride_width_p-1:0] gen_stride_o
 ,output logic [id_width_lp-1:0] grant_id_o
);

  typedef enum logic [1:0] {e_idle, e_hold, e_gap} state_e;

  state_e state;
  logic [id_width_lp-1:0] ptr;
  logic [gap_width_p-1:0] cnt;

  logic found, arb_en, accept, drop, dup;
  logic [id_width_lp-1:0] winner, ptr_next;
  logic [vaddr_width_p-1:0] win_pc, win_addr;
  logic [loop_range_p-1:0] win_loop;
  logic [stride_width_p-1:0] win_stride;
  int best_d, d;

  // Pick the valid requester closest to the pointer, counting upward with wrap.
  always_comb begin
    found = 1'b0;
    winner = '0;
    win_pc = '0;
    win_addr = '0;
    win_loop = '0;
    win_stride = '0;
    best_d = num_req_p;
    d = 0;
    for (int i = 0; i < num_req_p; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + num_req_p;
      if (req_v_i[i] && d < best_d) begin
        best_d = d;
        found = 1'b1;
        winner = id_width_lp'(i);
        win_pc = req_pc_i[i*vaddr_width_p +: vaddr_width_p];
        win_addr = req_eff_addr_i[i*vaddr_width_p +: vaddr_width_p];
        win_loop = req_loop_counter_i[i*loop_range_p +: loop_range_p];
        win_stride = req_stride_i[i*stride_width_p +: stride_width_p];
      end
    end
  end

  assign arb_en = !reset_i && (state == e_idle) && enable_i && !flush_i;
  assign accept = arb_en && found;
  assign ptr_next = (winner == id_width_lp'(num_req_p - 1))
                  ? '0 : winner + id_width_lp'(1);

  always_comb begin
    req_ready_and_o = '0;
    for (int i = 0; i < num_req_p; i++)
      req_ready_and_o[i] = accept && (winner == id_width_lp'(i));
  end

`ifdef BP_BE_PREFETCH_SCHED_DEDUP_EN
  localparam int blk_shift_lp = $clog2(dcache_block_width_p / 8);
  logic last_v;
  logic [vaddr_width_p-1:0] last_pc, last_blk;

  assign dup = last_v && (last_pc == win_pc)
            && (last_blk == (win_addr >> blk_shift_lp));

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      last_v <= 1'b0;
      last_pc <= '0;
      last_blk <= '0;
    end else if (gen_v_o && gen_ready_and_i) begin
      last_v <= 1'b1;
      last_pc <= gen_pc_o;
      last_blk <= gen_eff_addr_o >> blk_shift_lp;
    end
  end
`else
  assign dup = 1'b0;
`endif

  assign drop = (win_loop == '0) || (win_stride == '0) || dup;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= e_idle;
      ptr <= '0;
      cnt <= '0;
      gen_v_o <= 1'b0;
      gen_pc_o <= '0;
      gen_loop_counter_o <= '0;
      gen_eff_addr_o <= '0;
      gen_stride_o <= '0;
      grant_id_o <= '0;
    end else if (flush_i) begin
      state <= e_idle;
      cnt <= '0;
      gen_v_o <= 1'b0;
    end else begin
      unique case (state)
        e_idle: if (accept) begin
          ptr <= ptr_next;
          if (!drop) begin
            state <= e_hold;
            gen_v_o <= 1'b1;
            gen_pc_o <= win_pc;
            gen_loop_counter_o <= win_loop;
            gen_eff_addr_o <= win_addr;
            gen_stride_o <= win_stride;
            grant_id_o <= winner;
          end
        end
        e_hold: if (gen_ready_and_i) begin
          gen_v_o <= 1'b0;
          cnt <= gap_i;
          state <= (gap_i == '0) ? e_idle : e_gap;
        end
        e_gap: begin
          cnt <= cnt - gap_width_p'(1);
          if (cnt <= gap_width_p'(1)) begin
            cnt <= '0;
            state <= e_idle;
          end
        end
        default: state <= e_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_prefetch_scheduler.sv
// Randomized bench for bp_be_prefetch_scheduler against a transaction-level model.
// Covers forwarding, round robin, backpressure, gap, drops, flush and optional dedup.
module tb_bp_be_prefetch_scheduler;
  localparam int N = 3;
  localparam int VA = 39;
  localparam int LR = 8;
  localparam int SW = 8;
  localparam int GW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, flush, gen_rdy;
  logic [GW-1:0] gap;
  logic [N-1:0] v, rdy;
  logic [VA-1:0] pc [N];
  logic [VA-1:0] addr [N];
  logic [LR-1:0] lp [N];
  logic [SW-1:0] st [N];
  logic [N*VA-1:0] pc_bus, addr_bus;
  logic [N*LR-1:0] lp_bus;
  logic [N*SW-1:0] st_bus;
  logic gen_v;
  logic [VA-1:0] gen_pc, gen_addr;
  logic [LR-1:0] gen_lp;
  logic [SW-1:0] gen_st;
  logic [IW-1:0] gid;

  always_comb begin
    pc_bus = '0; addr_bus = '0; lp_bus = '0; st_bus = '0;
    for (int i = 0; i < N; i++) begin
      pc_bus[i*VA +: VA] = pc[i];
      addr_bus[i*VA +: VA] = addr[i];
      lp_bus[i*LR +: LR] = lp[i];
      st_bus[i*SW +: SW] = st[i];
    end
  end

  bp_be_prefetch_scheduler #(
    .vaddr_width_p(VA), .num_req_p(N), .loop_range_p(LR),
    .stride_width_p(SW), .gap_width_p(GW)
  ) dut (
    .clk_i(clk), .reset_i(rst), .enable_i(en), .flush_i(flush),
    .gap_i(gap), .req_v_i(v), .req_ready_and_o(rdy),
    .req_pc_i(pc_bus), .req_loop_counter_i(lp_bus),
    .req_eff_addr_i(addr_bus), .req_stride_i(st_bus),
    .gen_v_o(gen_v), .gen_ready_and_i(gen_rdy),
    .gen_pc_o(gen_pc), .gen_loop_counter_o(gen_lp),
    .gen_eff_addr_o(gen_addr), .gen_stride_o(gen_st),
    .grant_id_o(gid)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
  endtask

`ifdef BP_BE_PREFETCH_SCHED_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  // Transaction model: a held request, remaining cooldown, rotating pointer.
  int ptr = 0, cool = 0, h_id = 0;
  bit held = 0, d_v = 0;
  logic [VA-1:0] h_pc, h_addr, d_pc, d_blk;
  logic [LR-1:0] h_lp;
  logic [SW-1:0] h_st;
  int acc_q[$];
  int fwd = 0;

  function automatic int pick();
    for (int i = 0; i < N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic compare();
    int w;
    logic [N-1:0] er;
    w = pick();
    er = '0;
    if (!rst && !held && cool == 0 && en && !flush && w >= 0) er[w] = 1'b1;
    chk("ready", 64'(rdy), 64'(er));
    chk("gen_v", 64'(gen_v), 64'(held));
    if (held) begin
      chk("pc", 64'(gen_pc), 64'(h_pc));
      chk("addr", 64'(gen_addr), 64'(h_addr));
      chk("loop", 64'(gen_lp), 64'(h_lp));
      chk("stride", 64'(gen_st), 64'(h_st));
      chk("grant", 64'(gid), 64'(h_id));
    end
    for (int i = 0; i < N; i++) if (rdy[i]) acc_q.push_back(i);
    if (gen_v && gen_rdy) fwd++;
  endtask

  task automatic model_next();
    int w;
    bit drop;
    w = pick();
    if (rst) begin
      ptr = 0; cool = 0; held = 0; d_v = 0;
    end else if (flush) begin
      held = 0; cool = 0; d_v = 0;
    end else if (held) begin
      if (gen_rdy) begin
        held = 0; cool = int'(gap);
        d_v = 1; d_pc = h_pc; d_blk = h_addr >> 6;
      end
    end else if (cool > 0) begin
      cool--;
    end else if (en && w >= 0) begin
      ptr = (w + 1) % N;
      drop = (lp[w] == 0) || (st[w] == 0) ||
             (DEDUP && d_v && d_pc == pc[w] && d_blk == (addr[w] >> 6));
      if (!drop) begin
        held = 1; h_id = w;
        h_pc = pc[w]; h_addr = addr[w]; h_lp = lp[w]; h_st = st[w];
      end
    end
  endtask

  // Inputs are set just after a negedge; returns at the next negedge.
  task automatic tick();
    #1;
    compare();
    model_next();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [VA-1:0] p,
                         input logic [LR-1:0] l, input logic [VA-1:0] a,
                         input logic [SW-1:0] s);
    pc[i] = p; lp[i] = l; addr[i] = a; st[i] = s;
  endtask

  initial begin
    int n;
    rst = 1; en = 1; flush = 0; gen_rdy = 1; gap = 0; v = '0;
    for (int i = 0; i < N; i++) set_req(i, '0, '0, '0, '0);
    @(negedge clk);
    tick();
    tick();
    chk("rst_pc", 64'(gen_pc), 64'h0);
    chk("rst_gid", 64'(gid), 64'h0);
    rst = 0;

    // single forward
    set_req(0, 39'h1000, 8'd4, 39'h8000, 8'd8);
    v = 3'b001;
    #1 chk("sf_ready", 64'(rdy), 64'h1);
    tick();
    v = 3'b000;
    chk("sf_gen_v", 64'(gen_v), 64'h1);
    chk("sf_pc", 64'(gen_pc), 64'h1000);
    chk("sf_gid", 64'(gid), 64'h0);
    tick();
    chk("sf_done", 64'(gen_v), 64'h0);

    // round robin between requesters 0 and 1
    set_req(1, 39'h2000, 8'd3, 39'h9000, 8'd4);
    v = 3'b011;
    acc_q.delete();
    for (int i = 0; i < 8; i++) tick();
    chk("rr_cnt", 64'(acc_q.size()), 64'd4);
    for (int i = 1; i < acc_q.size(); i++)
      chk("rr_alt", 64'(acc_q[i] != acc_q[i-1]), 64'h1);
    v = 3'b000;
    tick();

    // backpressure then gap of 3
    gen_rdy = 0; gap = 3;
    set_req(0, 39'h1000, 8'd4, 39'h8000, 8'd8);
    v = 3'b001;
    tick();
    set_req(0, 39'h1234, 8'd5, 39'h8800, 8'd9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_pc", 64'(gen_pc), 64'h1000);
      tick();
    end
    gen_rdy = 1;
    tick();
    n = 0;
    while (rdy == '0 && n < 10) begin
      n++;
      tick();
    end
    chk("gap_len", 64'(n), 64'd3);
    tick();
    v = 3'b000;
    gap = 0;
    tick();
    tick();

    // degenerate drops
    set_req(2, 39'h3000, 8'd0, 39'hA000, 8'd8);
    v = 3'b100;
    tick();
    set_req(2, 39'h3000, 8'd2, 39'hA000, 8'd0);
    tick();
    v = 3'b000;
    chk("drop_gen_v", 64'(gen_v), 64'h0);
    tick();

    // flush in second hold cycle
    gen_rdy = 0;
    set_req(0, 39'h1000, 8'd4, 39'h8000, 8'd8);
    v = 3'b001;
    tick();
    tick();
    flush = 1;
    tick();
    flush = 0;
    #1 chk("fl_gen_v", 64'(gen_v), 64'h0);
    chk("fl_accept", 64'(|rdy), 64'h1);
    tick();
    gen_rdy = 1;
    v = 3'b000;
    tick();
    tick();

    // same pc, same 64B block twice
    flush = 1;
    tick();
    flush = 0;
    fwd = 0;
    set_req(0, 39'h1000, 8'd4, 39'h8000, 8'd8);
    v = 3'b001;
    tick();
    v = 3'b000;
    tick();
    set_req(0, 39'h1000, 8'd4, 39'h8010, 8'd8);
    v = 3'b001;
    tick();
    v = 3'b000;
    tick();
    tick();
    chk("dedup_fwd", 64'(fwd), DEDUP ? 64'd1 : 64'd2);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      gen_rdy = ($urandom_range(0, 9) < 6);
      gap = GW'($urandom_range(0, 3));
      v = N'($urandom);
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(0, 1) != 0) ? 39'h1000 : 39'h2000,
                LR'($urandom_range(0, 3)),
                39'h8000 + 39'(16 * $urandom_range(0, 7)),
                SW'($urandom_range(0, 3)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
